// File: rtl/theta_iter_gen_pkg.sv
// Shared definitions for the theta sequencing stages: FSM encoding,
// global index width and a helper that sizes small index counters.
package theta_iter_gen_pkg;

  localparam int IT_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width for a counter covering 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/theta_iter_gen_rise_det.sv
// Registered rising-edge detector: remembers last cycle's level and flags
// a 0->1 transition on the current input.
module theta_iter_gen_rise_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/theta_iter_gen.sv
// Sequencer issuing global scan-point indices to the theta-cosine stage,
// paced by a minimum tick period and gated by the downstream result ack.
module theta_iter_gen
  import theta_iter_gen_pkg::*;
#(
  parameter int POINTS_PER_LINE_P  = 360,
  parameter int NUMBER_OF_FRAMES_P = 5,
  parameter int TICKS_PER_POINT_P  = 100,
  localparam int TOTAL_POINTS_P    = POINTS_PER_LINE_P * NUMBER_OF_FRAMES_P,
  localparam int PT_W              = idx_w(POINTS_PER_LINE_P),
  localparam int FR_W              = idx_w(NUMBER_OF_FRAMES_P)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            result_valid_i,
  output logic            theta_iteration_valid_o,
  output logic [IT_W-1:0] theta_iteration_o,
  output logic [PT_W-1:0] point_idx_o,
  output logic [FR_W-1:0] frame_idx_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            overrun_o
);

  localparam int TK_W = idx_w(TICKS_PER_POINT_P);
  localparam logic [TK_W-1:0] TICK_LAST = TK_W'(TICKS_PER_POINT_P - 2);
  localparam logic [IT_W-1:0] IT_LAST   = IT_W'(TOTAL_POINTS_P - 1);
  localparam logic [PT_W-1:0] PT_LAST   = PT_W'(POINTS_PER_LINE_P - 1);

  state_e            state_q, state_d;
  logic [TK_W-1:0]   tick_q, tick_d;
  logic              ack_q, ack_d;
  logic [IT_W-1:0]   it_q, it_d;
  logic [PT_W-1:0]   pt_q, pt_d;
  logic [FR_W-1:0]   fr_q, fr_d;
  logic              ovr_q, ovr_d;
  logic              valid_q, busy_q, done_q;
  logic              rise;
  logic              ack_seen;
  logic              deadline;

  theta_iter_gen_rise_det u_rise_det (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sig_i  (result_valid_i),
    .rise_o (rise)
  );

  // tick_q saturates at TICK_LAST, which is the last WAIT cycle before the
  // minimum period expires; an ack in that same cycle still counts.
  assign deadline = (tick_q == TICK_LAST);
  assign ack_seen = ack_q | rise;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    ack_d   = ack_q;
    it_d    = it_q;
    pt_d    = pt_q;
    fr_d    = fr_q;
    ovr_d   = ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          state_d = ST_ISSUE;
          it_d    = '0;
          pt_d    = '0;
          fr_d    = '0;
          ovr_d   = 1'b0;
        end
      end
      ST_ISSUE: begin
        tick_d  = '0;
        ack_d   = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tick_q != TICK_LAST) begin
          tick_d = tick_q + TK_W'(1);
        end
        if (rise) begin
          ack_d = 1'b1;
        end
        if (deadline) begin
          if (!ack_seen) begin
            ovr_d = 1'b1;
          end else if (it_q == IT_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            it_d    = it_q + IT_W'(1);
            if (pt_q == PT_LAST) begin
              pt_d = '0;
              fr_d = fr_q + FR_W'(1);
            end else begin
              pt_d = pt_q + PT_W'(1);
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything; the overrun history survives it.
    if (stop_i) begin
      state_d = ST_IDLE;
      tick_d  = '0;
      ack_d   = 1'b0;
      it_d    = '0;
      pt_d    = '0;
      fr_d    = '0;
      ovr_d   = ovr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      ack_q   <= 1'b0;
      it_q    <= '0;
      pt_q    <= '0;
      fr_q    <= '0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
      it_q    <= it_d;
      pt_q    <= pt_d;
      fr_q    <= fr_d;
      ovr_q   <= ovr_d;
      valid_q <= (state_d == ST_ISSUE);
      busy_q  <= (state_d == ST_ISSUE) || (state_d == ST_WAIT);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign theta_iteration_valid_o = valid_q;
  assign theta_iteration_o       = it_q;
  assign point_idx_o             = pt_q;
  assign frame_idx_o             = fr_q;
  assign busy_o                  = busy_q;
  assign done_o                  = done_q;
  assign overrun_o               = ovr_q;

endmodule

// File: tb/tb_theta_iter_gen.sv
// Directed bench for theta_iter_gen with PPL=3, FRAMES=2, TICKS=4 (six points).
module tb_theta_iter_gen;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        startIn = 1'b0;
  logic        stopIn = 1'b0;
  logic        resultValid = 1'b0;
  logic        iterValid;
  logic [11:0] iterIdx;
  logic [1:0]  pointIdx;
  logic [0:0]  frameIdx;
  logic        busyOut;
  logic        doneOut;
  logic        overrunOut;

  int testCount = 0;
  int failCount = 0;

  theta_iter_gen #(
    .POINTS_PER_LINE_P  (3),
    .NUMBER_OF_FRAMES_P (2),
    .TICKS_PER_POINT_P  (4)
  ) dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .start_i                 (startIn),
    .stop_i                  (stopIn),
    .result_valid_i          (resultValid),
    .theta_iteration_valid_o (iterValid),
    .theta_iteration_o       (iterIdx),
    .point_idx_o             (pointIdx),
    .frame_idx_o             (frameIdx),
    .busy_o                  (busyOut),
    .done_o                  (doneOut),
    .overrun_o               (overrunOut)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and settle just past the edge before looking.
  task automatic stepCycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic rv);
    startIn     = s;
    stopIn      = p;
    resultValid = rv;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag, input logic [31:0] expOverrun);
    checkOutput({tag, " valid"},   32'(iterValid),  0);
    checkOutput({tag, " busy"},    32'(busyOut),    0);
    checkOutput({tag, " done"},    32'(doneOut),    0);
    checkOutput({tag, " overrun"}, 32'(overrunOut), expOverrun);
  endtask

  task automatic checkIssue(input string tag, input int idx, input int pt, input int fr);
    checkOutput({tag, " valid"}, 32'(iterValid), 1);
    checkOutput({tag, " busy"},  32'(busyOut),   1);
    checkOutput({tag, " iter"},  32'(iterIdx),   idx);
    checkOutput({tag, " point"}, 32'(pointIdx),  pt);
    checkOutput({tag, " frame"}, 32'(frameIdx),  fr);
  endtask

  initial begin
    // 1: reset, then idle with result_valid toggling
    rst_i = 1'b1;
    stepCycle(2);
    rst_i = 1'b0;
    checkIdle("reset", 0);
    checkOutput("reset iter", 32'(iterIdx), 0);
    checkOutput("reset point", 32'(pointIdx), 0);
    checkOutput("reset frame", 32'(frameIdx), 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, logic'(i % 2 == 0));
      stepCycle();
      checkOutput("idle toggle valid", 32'(iterValid), 0);
    end
    applyStimulus(0, 0, 0);
    stepCycle();
    checkIdle("idle after toggle", 0);

    // 2: full sweep, ack two cycles after each issue
    applyStimulus(1, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      checkIssue("sweep issue", k, k % 3, k / 3);
      stepCycle();
      checkOutput("sweep wait valid", 32'(iterValid), 0);
      stepCycle();
      applyStimulus(0, 0, 1);
      stepCycle();
      applyStimulus(0, 0, 0);
      checkOutput("sweep hold iter", 32'(iterIdx), k);
      checkOutput("sweep no done", 32'(doneOut), 0);
      stepCycle();
    end
    checkOutput("sweep done pulse", 32'(doneOut), 1);
    checkOutput("sweep done busy", 32'(busyOut), 0);
    checkOutput("sweep done valid", 32'(iterValid), 0);
    stepCycle();
    checkIdle("sweep after done", 0);
    stepCycle(3);
    checkOutput("sweep no re-issue", 32'(iterValid), 0);

    // 3: late ack sets overrun; issue follows the ack by one cycle
    applyStimulus(1, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0);
    checkIssue("ovr issue0", 0, 0, 0);
    stepCycle(3);
    checkOutput("ovr before deadline", 32'(overrunOut), 0);
    stepCycle();
    checkOutput("ovr at deadline", 32'(overrunOut), 1);
    checkOutput("ovr no issue at deadline", 32'(iterValid), 0);
    stepCycle();
    checkOutput("ovr still waiting", 32'(iterValid), 0);
    stepCycle();
    applyStimulus(0, 0, 1);
    checkOutput("ovr ack cycle valid", 32'(iterValid), 0);
    stepCycle();
    applyStimulus(0, 0, 0);
    checkIssue("ovr issue1", 1, 1, 0);
    checkOutput("ovr sticky", 32'(overrunOut), 1);

    // 4: stop mid-sweep, overrun survives, restart from zero
    stepCycle(2);
    applyStimulus(0, 1, 0);
    stepCycle();
    applyStimulus(0, 0, 0);
    checkIdle("stop", 1);
    checkOutput("stop iter", 32'(iterIdx), 0);
    checkOutput("stop point", 32'(pointIdx), 0);
    checkOutput("stop frame", 32'(frameIdx), 0);
    stepCycle(6);
    checkIdle("stop later", 1);
    applyStimulus(1, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0);
    checkIssue("restart", 0, 0, 0);
    checkOutput("restart clears overrun", 32'(overrunOut), 0);

    // 5: start while busy is ignored; start with stop in idle stays idle
    stepCycle(2);
    applyStimulus(1, 0, 1);
    stepCycle();
    applyStimulus(0, 0, 0);
    checkOutput("busy start no issue", 32'(iterValid), 0);
    stepCycle();
    checkIssue("busy start seq", 1, 1, 0);
    applyStimulus(0, 1, 0);
    stepCycle();
    applyStimulus(0, 0, 0);
    checkIdle("stop again", 0);
    applyStimulus(1, 1, 0);
    stepCycle();
    applyStimulus(0, 0, 0);
    checkIdle("start+stop", 0);
    stepCycle();
    checkIdle("start+stop later", 0);

    // 6: reset mid-sweep, later ack ignored, clean restart
    applyStimulus(1, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0);
    checkIssue("pre-reset issue0", 0, 0, 0);
    stepCycle(2);
    applyStimulus(0, 0, 1);
    stepCycle();
    applyStimulus(0, 0, 0);
    stepCycle();
    checkIssue("pre-reset issue1", 1, 1, 0);
    stepCycle();
    rst_i = 1'b1;
    stepCycle();
    rst_i = 1'b0;
    checkIdle("mid reset", 0);
    checkOutput("mid reset iter", 32'(iterIdx), 0);
    checkOutput("mid reset point", 32'(pointIdx), 0);
    applyStimulus(0, 0, 1);
    stepCycle();
    applyStimulus(0, 0, 0);
    stepCycle();
    checkIdle("ack after reset", 0);
    applyStimulus(1, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0);
    checkIssue("post-reset issue", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
